// File: rtl/rv32imf_apu_wb_buf.sv
// APU result write-back buffer: bypasses results straight to the register-file write port when it is free,
// otherwise queues them in program order and drains them when the port frees up.
module rv32imf_apu_wb_buf #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned FLAGS_W = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         apu_rvalid_i,
  input  logic [DATA_W-1:0]            apu_result_i,
  input  logic [FLAGS_W-1:0]           apu_flags_i,
  input  logic [ADDR_W-1:0]            apu_waddr_i,
  input  logic                         wb_port_busy_i,
  input  logic [3*ADDR_W-1:0]          read_regs_i,
  input  logic [2:0]                   read_regs_valid_i,
  output logic                         regfile_we_o,
  output logic [ADDR_W-1:0]            regfile_waddr_o,
  output logic [DATA_W-1:0]            regfile_wdata_o,
  output logic                         fflags_we_o,
  output logic [FLAGS_W-1:0]           fflags_o,
  output logic                         read_dep_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         stall_o,
  output logic                         overflow_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0]  waddr;
    logic [DATA_W-1:0]  data;
    logic [FLAGS_W-1:0] flags;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;

  logic              empty, full, drain, bypass, push, drop;
  logic              dep;
  logic [PTR_W-1:0]  idx;
  entry_t            head;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign drain  = !wb_port_busy_i && !empty;
  assign bypass = apu_rvalid_i && !wb_port_busy_i && empty;
  // A full FIFO may still accept a push on a cycle it also pops.
  assign push   = apu_rvalid_i && !bypass && (!full || drain);
  assign drop   = apu_rvalid_i && !bypass && full && !drain;
  assign head   = mem_q[rptr_q];

  // Pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wptr_q <= (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
      if (drain) rptr_q <= (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
      if (push && !drain)      count_q <= count_q + CNT_W'(1);
      else if (drain && !push) count_q <= count_q - CNT_W'(1);
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Entry storage; validity is tracked by the pointers alone
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= '{waddr: apu_waddr_i, data: apu_result_i, flags: apu_flags_i};
  end

  // Write-port mux: bypass or head-of-queue, zeros when idle
  always_comb begin
    regfile_we_o    = 1'b0;
    regfile_waddr_o = '0;
    regfile_wdata_o = '0;
    fflags_we_o     = 1'b0;
    fflags_o        = '0;
    if (!rst_i) begin
      if (bypass) begin
        regfile_we_o    = 1'b1;
        regfile_waddr_o = apu_waddr_i;
        regfile_wdata_o = apu_result_i;
        fflags_we_o     = 1'b1;
        fflags_o        = apu_flags_i;
      end else if (drain) begin
        regfile_we_o    = 1'b1;
        regfile_waddr_o = head.waddr;
        regfile_wdata_o = head.data;
        fflags_we_o     = 1'b1;
        fflags_o        = head.flags;
      end
    end
  end

  // Hazard: an ID source targets a buffered entry that is not retiring this cycle, or the incoming result
  always_comb begin
    dep = 1'b0;
    idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = PTR_W'((32'(rptr_q) + k) % DEPTH);
      if ((CNT_W'(k) < count_q) && !((k == 0) && drain)) begin
        for (int unsigned j = 0; j < 3; j++) begin
          if (read_regs_valid_i[j] && (read_regs_i[j*ADDR_W +: ADDR_W] == mem_q[idx].waddr)) dep = 1'b1;
        end
      end
    end
    if (apu_rvalid_i && !bypass) begin
      for (int unsigned j = 0; j < 3; j++) begin
        if (read_regs_valid_i[j] && (read_regs_i[j*ADDR_W +: ADDR_W] == apu_waddr_i)) dep = 1'b1;
      end
    end
  end

  assign read_dep_o = dep && !rst_i;
  assign count_o    = count_q;
  assign stall_o    = (count_q >= CNT_W'(DEPTH - 1));
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_rv32imf_apu_wb_buf.sv
// Directed bench for rv32imf_apu_wb_buf: expected register-file writes go into a queue
// and a negedge monitor compares every write the DUT performs.
module tb_rv32imf_apu_wb_buf;

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned FLAGS_W = 5;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0]  waddr;
    logic [DATA_W-1:0]  data;
    logic [FLAGS_W-1:0] flags;
  } wr_t;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 apu_rvalid_i;
  logic [DATA_W-1:0]    apu_result_i;
  logic [FLAGS_W-1:0]   apu_flags_i;
  logic [ADDR_W-1:0]    apu_waddr_i;
  logic                 wb_port_busy_i;
  logic [3*ADDR_W-1:0]  read_regs_i;
  logic [2:0]           read_regs_valid_i;
  logic                 regfile_we_o;
  logic [ADDR_W-1:0]    regfile_waddr_o;
  logic [DATA_W-1:0]    regfile_wdata_o;
  logic                 fflags_we_o;
  logic [FLAGS_W-1:0]   fflags_o;
  logic                 read_dep_o;
  logic [CNT_W-1:0]     count_o;
  logic                 stall_o;
  logic                 overflow_o;

  rv32imf_apu_wb_buf #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FLAGS_W(FLAGS_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .apu_rvalid_i(apu_rvalid_i), .apu_result_i(apu_result_i), .apu_flags_i(apu_flags_i),
    .apu_waddr_i(apu_waddr_i), .wb_port_busy_i(wb_port_busy_i),
    .read_regs_i(read_regs_i), .read_regs_valid_i(read_regs_valid_i),
    .regfile_we_o(regfile_we_o), .regfile_waddr_o(regfile_waddr_o), .regfile_wdata_o(regfile_wdata_o),
    .fflags_we_o(fflags_we_o), .fflags_o(fflags_o), .read_dep_o(read_dep_o),
    .count_o(count_o), .stall_o(stall_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int  n_checks = 0;
  int  n_fails  = 0;
  wr_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the oldest expected write; idle outputs must be zero
  always @(negedge clk_i) begin
    if (regfile_we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 32'(regfile_waddr_o), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wb_waddr", 32'(regfile_waddr_o), 32'(e.waddr));
        check("wb_wdata", regfile_wdata_o, e.data);
        check("wb_fflags_we", 32'(fflags_we_o), 32'd1);
        check("wb_fflags", 32'(fflags_o), 32'(e.flags));
      end
    end else begin
      check("idle_zero", {regfile_waddr_o, fflags_o, fflags_we_o}, 32'd0);
      check("idle_wdata_zero", regfile_wdata_o, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [FLAGS_W-1:0] f, input logic busy);
    apu_rvalid_i   = v;
    apu_waddr_i    = v ? a : '0;
    apu_result_i   = v ? d : '0;
    apu_flags_i    = v ? f : '0;
    wb_port_busy_i = busy;
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [FLAGS_W-1:0] f);
    wr_t e;
    e.waddr = a; e.data = d; e.flags = f;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0);
    read_regs_i = '0;
    read_regs_valid_i = '0;
    repeat (2) step();
    sample();
    check("reset_count", 32'(count_o), 32'd0);
    check("reset_stall", 32'(stall_o), 32'd0);
    check("reset_overflow", 32'(overflow_o), 32'd0);
    step();
    rst_i = 1'b0;
    step();

    // Bypass into an empty buffer
    drive(1'b1, 6'd5, 32'h3F80_0000, 5'h01, 1'b0);
    expect_wr(6'd5, 32'h3F80_0000, 5'h01);
    sample();
    check("bypass_we", 32'(regfile_we_o), 32'd1);
    step();
    check("bypass_count", 32'(count_o), 32'd0);
    drive(1'b0, '0, '0, '0, 1'b0);

    // Busy port: r7, r8 queue up
    drive(1'b1, 6'd7, 32'h4000_0000, 5'h02, 1'b1);
    expect_wr(6'd7, 32'h4000_0000, 5'h02);
    step();
    check("busy_count1", 32'(count_o), 32'd1);
    check("busy_stall1", 32'(stall_o), 32'd1);
    drive(1'b1, 6'd8, 32'h4040_0000, 5'h04, 1'b1);
    expect_wr(6'd8, 32'h4040_0000, 5'h04);
    step();
    check("busy_count2", 32'(count_o), 32'd2);
    check("busy_overflow", 32'(overflow_o), 32'd0);
    drive(1'b0, '0, '0, '0, 1'b1);
    sample();
    check("busy_we", 32'(regfile_we_o), 32'd0);
    step();

    // Full with drain: r7 written, r9 pushed, count holds at 2
    drive(1'b1, 6'd9, 32'h4080_0000, 5'h08, 1'b0);
    expect_wr(6'd9, 32'h4080_0000, 5'h08);
    sample();
    check("full_drain_we", 32'(regfile_we_o), 32'd1);
    step();
    check("full_drain_count", 32'(count_o), 32'd2);
    drive(1'b0, '0, '0, '0, 1'b0);
    step();
    check("drain_count1", 32'(count_o), 32'd1);
    step();
    check("drain_count0", 32'(count_o), 32'd0);
    check("drain_stall0", 32'(stall_o), 32'd0);

    // Read dependency on f10 (addr 42) through read_regs[1]
    read_regs_i = {6'd3, 6'd42, 6'd1};
    read_regs_valid_i = 3'b010;
    drive(1'b1, 6'd42, 32'hBF80_0000, 5'h10, 1'b1);
    expect_wr(6'd42, 32'hBF80_0000, 5'h10);
    sample();
    check("dep_incoming", 32'(read_dep_o), 32'd1);
    step();
    drive(1'b0, '0, '0, '0, 1'b1);
    sample();
    check("dep_buffered", 32'(read_dep_o), 32'd1);
    read_regs_valid_i = 3'b101;
    #1;
    check("dep_invalid_src", 32'(read_dep_o), 32'd0);
    read_regs_valid_i = 3'b010;
    step();
    wb_port_busy_i = 1'b0;
    sample();
    check("dep_draining", 32'(read_dep_o), 32'd0);
    step();
    read_regs_valid_i = '0;

    // Duplicate destination: both writes retire in order
    drive(1'b1, 6'd3, 32'h0000_1111, 5'h00, 1'b1);
    expect_wr(6'd3, 32'h0000_1111, 5'h00);
    step();
    drive(1'b1, 6'd3, 32'h0000_2222, 5'h1F, 1'b1);
    expect_wr(6'd3, 32'h0000_2222, 5'h1F);
    step();
    drive(1'b0, '0, '0, '0, 1'b0);
    repeat (2) step();
    check("dup_count0", 32'(count_o), 32'd0);

    // Overflow: fill while busy, then a dropped result
    drive(1'b1, 6'd1, 32'hAAAA_0001, 5'h01, 1'b1);
    step();
    drive(1'b1, 6'd2, 32'hAAAA_0002, 5'h02, 1'b1);
    step();
    drive(1'b1, 6'd4, 32'hDEAD_BEEF, 5'h03, 1'b1);
    step();
    check("ovf_set", 32'(overflow_o), 32'd1);
    check("ovf_count", 32'(count_o), 32'd2);
    drive(1'b0, '0, '0, '0, 1'b1);
    repeat (3) step();
    check("ovf_sticky", 32'(overflow_o), 32'd1);

    // Asynchronous reset with two entries buffered; they must never be written
    rst_i = 1'b1;
    wb_port_busy_i = 1'b0;
    #1;
    check("arst_count", 32'(count_o), 32'd0);
    check("arst_we", 32'(regfile_we_o), 32'd0);
    check("arst_overflow", 32'(overflow_o), 32'd0);
    step();
    rst_i = 1'b0;
    repeat (3) step();
    check("post_reset_count", 32'(count_o), 32'd0);

    // Post-reset bypass still works
    drive(1'b1, 6'd11, 32'h1234_5678, 5'h05, 1'b0);
    expect_wr(6'd11, 32'h1234_5678, 5'h05);
    step();
    drive(1'b0, '0, '0, '0, 1'b0);
    repeat (2) step();

    check("expected_left", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rv32imf_apu_wb_buf.md
Name: rv32imf_apu_wb_buf

Overview:
- Sits directly downstream of the APU dispatcher and the FPU/APU result channel, and upstream of the register-file write port.
- Captures every returned APU result, its destination address and its FP exception flags.
- Writes each result back when the shared write port is free. If the port is busy, it holds results in a small in-order FIFO.
- Reports pending-write hazards and back-pressure to the ID stage.

Parameters:
- DEPTH, 2, number of FIFO entries; must be ≥2.
- DATA_W, 32, result width.
- ADDR_W, 6, destination register address width (GPR/FPR unified space).
- FLAGS_W, 5, FP exception flag width (NV, DZ, OF, UF, NX).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- apu_rvalid_i  in  1  APU result valid this cycle
- apu_result_i  in  DATA_W  result data
- apu_flags_i  in  FLAGS_W  exception flags of the result
- apu_waddr_i  in  ADDR_W  destination address, from dispatcher apu_waddr_o
- wb_port_busy_i  in  1  ALU/LSU owns the write port this cycle; they have priority
- read_regs_i  in  3×ADDR_W  ID-stage source operand addresses
- read_regs_valid_i  in  3  source operand valids
- regfile_we_o  out  1  write-port enable
- regfile_waddr_o  out  ADDR_W  write address
- regfile_wdata_o  out  DATA_W  write data
- fflags_we_o  out  1  accumulate flags into fcsr.fflags
- fflags_o  out  FLAGS_W  flags to OR into fcsr
- read_dep_o  out  1  an ID source matches a buffered, unwritten entry
- count_o  out  $clog2(DEPTH+1)  entries held
- stall_o  out  1  count_o ≥ DEPTH-1; ID must not issue a new APU op
- overflow_o  out  1  sticky error: a result was lost

Behaviour:
- Reset (asynchronous, rst_i=1): FIFO empty, pointers 0, count_o=0, overflow_o=0. All outputs are 0; stall_o=0 unless DEPTH-1=0 (illegal). A reset mid-operation discards all entries immediately.
- Define: drain = !wb_port_busy_i & count>0; bypass = apu_rvalid_i & !wb_port_busy_i & count==0.
- Bypass, zero latency, combinational:
  - regfile_we_o=1, regfile_waddr_o=apu_waddr_i, regfile_wdata_o=apu_result_i.
  - fflags_we_o=1, fflags_o=apu_flags_i.
  - Nothing is enqueued.
- Drain:
  - Outputs are driven from the head entry with we=1 and fflags_we=1.
  - The head pops at the clock edge.
  - An arriving result never overtakes a buffered one; strict program order.
- Enqueue: apu_rvalid_i & !bypass enqueues {waddr, result, flags} at the tail.
- Simultaneous drain and enqueue: head is written and popped, new result is pushed; count unchanged.
- Full:
  - count==DEPTH with drain: the push and pop happen together, and this is legal.
  - count==DEPTH without drain while apu_rvalid_i=1: the result is dropped and overflow_o is set. overflow_o stays set until reset.
- wb_port_busy_i=1: regfile_we_o=0, fflags_we_o=0, and the FIFO holds.
- Idle outputs: when regfile_we_o=0, waddr/wdata/fflags outputs are 0.
- Pointers wrap modulo DEPTH; count saturates neither up nor down beyond its legal range.
- read_dep_o:
  - Asserted if any valid read_regs_i[i] equals the waddr of a buffered entry that is not being drained this cycle.
  - Also asserted if read_regs_i[i] equals apu_waddr_i while apu_rvalid_i & !bypass.
- Duplicate addresses in the FIFO are allowed; they drain in order, so the last write wins.
- stall_o is registered-free: combinational from count.

Test Plan:
- Port free, empty: rvalid with waddr=5, result=0x3F800000, flags=0x01 → same cycle regfile_we_o=1, waddr 5, data 0x3F800000, fflags_we_o=1, fflags_o=0x01; count_o stays 0.
- Port busy 3 cycles, results to r7 then r8 → count_o=1 then 2, stall_o=1, overflow_o=0. After busy drops, r7 is written, then r8 on the next cycle; count_o returns to 0.
- Full (count=2), busy=0, new rvalid to r9 → head written, r9 pushed, count_o stays 2. Write order is preserved: r7, r8, r9.
- Full, busy=1, rvalid → result dropped, overflow_o=1 and stays 1 until rst_i pulse.
- Entry for f10 (addr 42) buffered, ID read_regs_i[1]=42 valid → read_dep_o=1. On the cycle that entry drains → read_dep_o=0.
- Reset asserted with 2 entries buffered → count_o=0 and regfile_we_o=0 immediately (asynchronous). No stale writes after reset release.
